// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection phase sequencer: owns the seconds countdown, walks the
// green / yellow / all-red phases on an enabled 1 Hz tick and grants the side
// road only after a latched vehicle request.
module traffic_phase_ctrl #(
   parameter int pGREEN_MAIN = 30,
   parameter int pGREEN_SIDE = 20,
   parameter int pYELLOW     = 3,
   parameter int pALL_RED    = 1,
   localparam int MAX_A      = (pGREEN_MAIN > pGREEN_SIDE) ? pGREEN_MAIN : pGREEN_SIDE,
   localparam int MAX_B      = (pYELLOW > pALL_RED) ? pYELLOW : pALL_RED,
   localparam int MAX_DUR    = (MAX_A > MAX_B) ? MAX_A : MAX_B,
   localparam int W          = $clog2(MAX_DUR + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         tick,
   input  logic         side_req,
   output logic [2:0]   main_lights,
   output logic [2:0]   side_lights,
   output logic [W-1:0] remaining,
   output logic         last,
   output logic         pre_last,
   output logic         side_pending
);

   typedef enum logic [2:0] {
      ALL_RED_M   = 3'd0,
      MAIN_GREEN  = 3'd1,
      MAIN_YELLOW = 3'd2,
      ALL_RED_S   = 3'd3,
      SIDE_GREEN  = 3'd4,
      SIDE_YELLOW = 3'd5
   } state_t;

   // {R,Y,G} light codes
   localparam logic [2:0] L_RED = 3'b100;
   localparam logic [2:0] L_YEL = 3'b010;
   localparam logic [2:0] L_GRN = 3'b001;

   state_t         state_q, state_d;
   logic [W-1:0]   remaining_q, remaining_d;
   logic           pending_q, pending_d;
   logic           tick_eff;
   logic           pend_next;

   // Duration loaded on entry to each phase
   function automatic logic [W-1:0] dur(input state_t s);
      case (s)
         MAIN_GREEN:  dur = W'(pGREEN_MAIN);
         MAIN_YELLOW: dur = W'(pYELLOW);
         SIDE_GREEN:  dur = W'(pGREEN_SIDE);
         SIDE_YELLOW: dur = W'(pYELLOW);
         default:     dur = W'(pALL_RED);
      endcase
   endfunction

   assign tick_eff  = tick & en;
   // A request landing on the final main-green tick still counts
   assign pend_next = pending_q | side_req;

   // Next-state: countdown, phase transitions, illegal-encoding recovery
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      case (state_q)
         ALL_RED_M, MAIN_GREEN, MAIN_YELLOW,
         ALL_RED_S, SIDE_GREEN, SIDE_YELLOW: begin
            if (tick_eff) begin
               if (remaining_q > W'(1)) begin
                  remaining_d = remaining_q - W'(1);
               end else begin
                  case (state_q)
                     ALL_RED_M:   state_d = MAIN_GREEN;
                     MAIN_GREEN:  state_d = pend_next ? MAIN_YELLOW : MAIN_GREEN;
                     MAIN_YELLOW: state_d = ALL_RED_S;
                     ALL_RED_S:   state_d = SIDE_GREEN;
                     SIDE_GREEN:  state_d = SIDE_YELLOW;
                     default:     state_d = ALL_RED_M;
                  endcase
                  // Resting on main reloads the full green as well
                  remaining_d = dur(state_d);
               end
            end
         end
         default: begin
            state_d     = ALL_RED_M;
            remaining_d = W'(pALL_RED);
         end
      endcase
   end

   // Request latch: cleared on entry to and throughout side green, so requests
   // seen while the side road is already being served are dropped
   always_comb begin
      pending_d = pending_q | side_req;
      if (state_q == SIDE_GREEN || state_d == SIDE_GREEN) begin
         pending_d = 1'b0;
      end
   end

   // State registers with synchronous reset into the main-side all-red
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ALL_RED_M;
         remaining_q <= W'(pALL_RED);
         pending_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         pending_q   <= pending_d;
      end
   end

   // Light heads decoded from the registered state; anything unknown is red
   always_comb begin
      main_lights = L_RED;
      side_lights = L_RED;
      case (state_q)
         MAIN_GREEN:  main_lights = L_GRN;
         MAIN_YELLOW: main_lights = L_YEL;
         SIDE_GREEN:  side_lights = L_GRN;
         SIDE_YELLOW: side_lights = L_YEL;
         default: begin
            main_lights = L_RED;
            side_lights = L_RED;
         end
      endcase
   end

   assign remaining    = remaining_q;
   assign last         = (remaining_q == W'(1));
   assign pre_last     = (remaining_q == W'(2));
   assign side_pending = pending_q;

endmodule
